booth_result_collector: RTL
===========================

Name: booth_result_collector

Overview:
- Downstream stage of the 16-bit Booth multiplier datapath/controller pair.
- Detects the multiplier's level `done` rising edge and captures the 32-bit product {A,Q}.
- Optionally accumulates the product into a signed accumulator (MAC mode).
- Queues results in a small FIFO, drained through a valid/ready interface by the consumer.

Parameters:
- WIDTH, 16, operand width; product width is 2*WIDTH.
- ACC_W, 40, accumulator and output word width; must be at least 2*WIDTH.
- DEPTH, 4, result FIFO depth; must be a power of two.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- done_i  in  1  multiplier done level (held high while the multiplier sits in its final state).
- prod_i  in  2*WIDTH  signed product {A,Q}; stable while done_i is high.
- acc_en_i  in  1  1 = push running accumulator sum; 0 = push sign-extended product only.
- clr_i  in  1  synchronous clear of accumulator and overflow flag.
- out_data_o  out  ACC_W  FIFO head.
- out_valid_o  out  1  FIFO non-empty.
- out_ready_i  in  1  consumer accepts the head when out_valid_o & out_ready_i.
- busy_o  out  1  FSM not in IDLE.
- ovf_o  out  1  sticky: a result was lost.
- acc_o  out  ACC_W  current accumulator value.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, done_q=0, prod_r=0, acc=0, FIFO empty. Outputs: out_valid_o=0, out_data_o=0, busy_o=0, ovf_o=0, acc_o=0. Reset mid-operation aborts the in-flight capture; nothing is pushed.
- Edge detect: done_q <= done_i each cycle; rise = done_i & ~done_q. A level held high produces exactly one rise.
- FSM states: IDLE, ACCUM, PUSH.
- IDLE: on rise, prod_r <= prod_i and go to ACCUM.
- ACCUM:
  - if acc_en_i, acc <= acc + sext(prod_r); wraps modulo 2^ACC_W.
  - res_r <= (acc_en_i ? acc + sext(prod_r) : sext(prod_r)).
  - go to PUSH.
- PUSH:
  - if the FIFO is not full, or a pop occurs this same cycle, write res_r.
  - otherwise discard res_r and set ovf_o.
  - go to IDLE.
- Latency: rise sampled at edge N -> out_valid_o high after edge N+3 when the FIFO was empty.
- Throughput: one result per 3 cycles; the multiplier needs far longer per product.
- A rise detected while in ACCUM or PUSH is not captured and sets ovf_o.
- Arithmetic: sext means sign-extend from bit 2*WIDTH-1 to ACC_W. All adds are two's-complement signed.
- clr_i priority over acc update, in every state:
  - acc <= 0 and ovf_o <= 0.
  - if asserted in ACCUM, the add is suppressed and res_r = sext(prod_r).
  - FIFO contents are untouched.
- clr_i in the same cycle as an overflow event: the clear wins and ovf_o ends at 0.
- FIFO:
  - push and pop in the same cycle are both accepted, in every occupancy state.
  - pointers are log2(DEPTH)+1 bits.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - pointers wrap naturally.
- out_data_o is valid only while out_valid_o=1. When empty it shows the last-read location; the consumer must not rely on it.

Optional Feature:
- Macro: BOOTH_ACC_SAT_EN.
- Defined: the accumulator saturates instead of wrapping.
  - on positive overflow, acc <= 2^(ACC_W-1)-1.
  - on negative overflow, acc <= -2^(ACC_W-1).
  - the saturated value is what res_r pushes.
  - an extra sticky output sat_o (1 bit, reset 0, cleared by clr_i) is present.
- Undefined: modulo wrap; no sat_o port.

Decomposition:
- Shared package booth_pkg holds:
  - WIDTH default 16 and ACC_W default 40.
  - state enum {IDLE, ACCUM, PUSH}.
  - sext helper function.
- One sub-module: booth_result_fifo, a synchronous FIFO parameterised on ACC_W and DEPTH. It has push/pop/full/empty ports, and its reset is on the same rst_n.

Test Plan:
- Basic capture: prod_i=0x00000031 (7*7), acc_en_i=0, done_i rises and stays high 20 cycles -> exactly one entry 0x0000000031, out_valid_o 3 cycles after the rise, busy_o high for 2 cycles.
- Negative product: prod_i=0xFFFFFFF1 (-15) -> entry 0xFFFFFFFFF1.
- MAC sequence: acc_en_i=1, products 49, -15, 100 -> entries 49, 34, 134; acc_o=134; clr_i then gives acc_o=0.
- FIFO full: out_ready_i=0, five done pulses -> four entries held, fifth lost, ovf_o=1. Then pop one with a simultaneous PUSH -> write accepted, no overflow, count stays 4.
- Rise during busy and reset mid-op: done_i toggles low/high while in ACCUM -> ovf_o=1. Then rst_n=0 during PUSH -> FIFO empty, all outputs 0 next cycle.
- With BOOTH_ACC_SAT_EN: acc preset near max by repeated 0x7FFFFFFF products with ACC_W=34 -> acc_o clamps at 0x1FFFFFFFF and sat_o=1; without the macro it wraps negative.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier result path.
package booth_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_ACC_W = 40;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PUSH
    } state_t;

    // Sign-extend the low w bits of v to 64 bits; callers slice to their word width (<= 64).
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic [63:0] sh;
        sh = v << (64 - w);
        return $signed(sh) >>> (64 - w);
    endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// Synchronous result FIFO with registered head; a newly written entry becomes visible one cycle later.
module booth_result_fifo
    import booth_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [ACC_W-1:0] wr_data,
    output logic [ACC_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ACC_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      rd_ptr_next;
    logic             valid_reg;
    logic [ACC_W-1:0] rd_data_reg;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop & valid_reg;
    assign push_ok = push & (~full | pop_ok);
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};

    assign empty   = ~valid_reg;
    assign rd_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Visibility uses the pre-push write pointer, so the head read never races the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            valid_reg   <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, push_ok};
            rd_ptr_reg <= rd_ptr_next;
            valid_reg  <= (wr_ptr_reg != rd_ptr_next);
            if (wr_ptr_reg != rd_ptr_next) begin
                rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/booth_result_collector.sv
// Captures Booth products on done rising edge, optionally accumulates, and queues results.
// Optional BOOTH_ACC_SAT_EN: saturating accumulator plus sticky sat_o output.
module booth_result_collector
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               done_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic               acc_en_i,
    input  logic               clr_i,
    output logic [ACC_W-1:0]   out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               ovf_o,
    output logic [ACC_W-1:0]   acc_o
`ifdef BOOTH_ACC_SAT_EN
    ,output logic              sat_o
`endif
);

    state_t             state_reg;
    logic               done_q_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   res_reg;
    logic               ovf_reg;
    logic [ACC_W-1:0]   prod_sx;
    logic [ACC_W-1:0]   acc_sum;
    logic               rise;
    logic               pop;
    logic               push;
    logic               lost;
    logic               fifo_full;
    logic               fifo_empty;

    assign rise    = done_i & ~done_q_reg;
    assign prod_sx = ACC_W'(sext(64'(prod_reg), 2 * WIDTH));

`ifdef BOOTH_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           sum_ovf;
    logic           sat_reg;

    assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {prod_sx[ACC_W-1], prod_sx};
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    // The true sign sits in the extra bit when the add overflows.
    assign acc_sum  = !sum_ovf ? sum_wide[ACC_W-1:0] :
                      sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_o    = sat_reg;
`else
    assign acc_sum  = acc_reg + prod_sx;
`endif

    assign out_valid_o = ~fifo_empty;
    assign pop         = out_valid_o & out_ready_i;
    assign push        = (state_reg == PUSH);
    assign lost        = push & fifo_full & ~pop;
    assign busy_o      = (state_reg != IDLE);
    assign ovf_o       = ovf_reg;
    assign acc_o       = acc_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            done_q_reg <= 1'b0;
            prod_reg   <= '0;
            acc_reg    <= '0;
            res_reg    <= '0;
            ovf_reg    <= 1'b0;
`ifdef BOOTH_ACC_SAT_EN
            sat_reg    <= 1'b0;
`endif
        end else begin
            done_q_reg <= done_i;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        prod_reg  <= prod_i;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc_en_i && !clr_i) begin
                        acc_reg <= acc_sum;
                        res_reg <= acc_sum;
`ifdef BOOTH_ACC_SAT_EN
                        if (sum_ovf) sat_reg <= 1'b1;
`endif
                    end else begin
                        res_reg <= prod_sx;
                    end
                    state_reg <= PUSH;
                end
                PUSH:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if ((rise && state_reg != IDLE) || lost) begin
                ovf_reg <= 1'b1;
            end
            // Clear is applied last so it wins over any same-cycle update.
            if (clr_i) begin
                acc_reg <= '0;
                ovf_reg <= 1'b0;
`ifdef BOOTH_ACC_SAT_EN
                sat_reg <= 1'b0;
`endif
            end
        end
    end

    booth_result_fifo #(
        .ACC_W (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (res_reg),
        .rd_data (out_data_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
